// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding, address field layout and block helpers.
package data_cache_pkg;

  localparam int WORD_BITS     = 32;
  localparam int BLOCK_WORDS   = 4;
  localparam int BLOCK_BITS    = 128;
  localparam int OFFSET_LSB    = 2;
  localparam int INDEX_LSB     = 4;
  localparam int MEM_ADDR_BITS = 28;

  typedef logic [1:0] cache_state_t;

  localparam cache_state_t ST_IDLE       = 2'd0;
  localparam cache_state_t ST_WRITE_BACK = 2'd1;
  localparam cache_state_t ST_MEM_READ   = 2'd2;
  localparam cache_state_t ST_UPDATE     = 2'd3;

  // Word 0 of a block lives in bits [31:0].
  function automatic logic [WORD_BITS-1:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                                      input logic [1:0] offset);
    return blk[{offset, 5'd0} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/data_cache_ctrl_fsm.sv
// Miss-handling controller: state register, next-state decode and the
// CPU stall / memory request outputs derived from the current state.
module dcache_ctrl_fsm
  import data_cache_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read,
  input  logic         write,
  input  logic         hit,
  input  logic         dirty,
  input  logic         mem_busywait,
  output cache_state_t state,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write
);

  cache_state_t next_state;
  logic         miss;

  assign miss = (read | write) & ~hit;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (miss) begin
          next_state = dirty ? ST_WRITE_BACK : ST_MEM_READ;
        end
      end
      ST_WRITE_BACK: begin
        if (!mem_busywait) begin
          next_state = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!mem_busywait) begin
          next_state = ST_UPDATE;
        end
      end
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Reset forces the stall low at once, even with a CPU request still held.
  assign busywait  = RESET & ((state != ST_IDLE) | miss);
  assign mem_read  = (state == ST_MEM_READ);
  assign mem_write = (state == ST_WRITE_BACK);

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache sitting between
// the CPU data port and a 128-bit block memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     busywait,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_BITS-1:0] mem_address,
  output logic [BLOCK_BITS-1:0]    mem_writedata,
  input  logic [BLOCK_BITS-1:0]    mem_readdata,
  input  logic                     mem_busywait
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_LSB - INDEX_BITS;

  logic [SETS-1:0]       valid;
  logic [SETS-1:0]       dirty;
  logic [TAG_BITS-1:0]   tag_array  [SETS];
  logic [BLOCK_BITS-1:0] data_array [SETS];
  logic [BLOCK_BITS-1:0] fill_block;
  logic [31:0]           readdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            offset;
  logic [1:0]            unused_byte_bits;
  logic                  hit;
  logic                  read_hit;
  logic                  write_hit;
  logic [31:0]           hit_word;
  cache_state_t          state;

  assign idx              = address[INDEX_LSB +: INDEX_BITS];
  assign tag              = address[31 -: TAG_BITS];
  assign offset           = address[OFFSET_LSB +: 2];
  assign unused_byte_bits = address[1:0];

  assign hit       = valid[idx] & (tag_array[idx] == tag);
  assign read_hit  = (state == ST_IDLE) & read & hit;
  assign write_hit = (state == ST_IDLE) & write & hit;
  assign hit_word  = block_word(data_array[idx], offset);

  dcache_ctrl_fsm u_ctrl (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .write        (write),
    .hit          (hit),
    .dirty        (dirty[idx]),
    .mem_busywait (mem_busywait),
    .state        (state),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write)
  );

  // Hits are served combinationally; the register keeps the last load visible.
  assign readdata = read_hit ? hit_word : readdata_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid      <= '0;
      dirty      <= '0;
      readdata_q <= '0;
      fill_block <= '0;
    end else begin
      if (read_hit) begin
        readdata_q <= hit_word;
      end
      if (write_hit) begin
        dirty[idx] <= 1'b1;
      end
      if ((state == ST_MEM_READ) && !mem_busywait) begin
        fill_block <= mem_readdata;
      end
      if (state == ST_UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (write_hit) begin
      data_array[idx][{offset, 5'd0} +: 32] <= writedata;
    end
    if (state == ST_UPDATE) begin
      data_array[idx] <= fill_block;
      tag_array[idx]  <= tag;
    end
  end

  // Write-back targets the resident line; refill targets the live request.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      ST_WRITE_BACK: begin
        mem_address   = {tag_array[idx], idx};
        mem_writedata = data_array[idx];
      end
      ST_MEM_READ: mem_address = {tag, idx};
      default: mem_address = '0;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomised self-checking bench for data_cache: a behavioural block memory
// plus an abstract line-level cache model predicting data, stalls and traffic.
module tb_data_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [127:0] init_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) begin
      b[w*32 +: 32] = {ba[23:0], 6'd0, 2'(w)} ^ 32'h5A00_0000;
    end
    return b;
  endfunction

  // Behavioural block memory, busy for a bench-chosen number of cycles.
  logic [127:0] mem_store [logic [27:0]];
  int           rd_lat = 0;
  int           wb_lat = 0;
  int           cur_lat = 0;
  int           busy_cnt = 0;
  bit           active = 1'b0;
  int           rd_tx = 0;
  int           wb_tx = 0;
  logic [27:0]  exp_rd_addr = '0;
  logic [27:0]  exp_wb_addr = '0;
  logic [127:0] exp_wb_data = '0;

  always @(negedge CLK) begin
    if (mem_read || mem_write) begin
      if (!active) begin
        active   = 1'b1;
        busy_cnt = 0;
        checkOutput("mem_excl", {127'd0, mem_read & mem_write}, 128'd0);
        if (mem_write) begin
          wb_tx++;
          cur_lat = wb_lat;
          checkOutput("wb_addr", {100'd0, mem_address}, {100'd0, exp_wb_addr});
          checkOutput("wb_data", mem_writedata, exp_wb_data);
        end else begin
          rd_tx++;
          cur_lat = rd_lat;
          checkOutput("rd_addr", {100'd0, mem_address}, {100'd0, exp_rd_addr});
        end
      end
      if (busy_cnt < cur_lat) begin
        mem_busywait = 1'b1;
        busy_cnt++;
      end else begin
        mem_busywait = 1'b0;
        active       = 1'b0;
        if (mem_write) begin
          mem_store[mem_address] = mem_writedata;
        end else begin
          mem_readdata = mem_store.exists(mem_address) ? mem_store[mem_address] : init_block(mem_address);
        end
      end
    end else begin
      active       = 1'b0;
      mem_busywait = 1'b0;
    end
  end

  // Abstract model: line contents per set plus the bench's view of memory.
  logic         mv [8];
  logic         md [8];
  logic [24:0]  mt [8];
  logic [127:0] mline [8];
  logic [127:0] model_mem [logic [27:0]];
  logic [31:0]  last_rd = '0;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
      mt[s] = '0;
      mline[s] = '0;
    end
    last_rd = '0;
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input int rlat, input int wlat);
    int          idx;
    int          off;
    int          stall;
    int          exp_stall;
    int          rd0;
    int          wb0;
    logic [24:0] tg;
    bit          hit;
    bit          was_dirty;
    logic [31:0] exp_word;
    idx = int'(addr[6:4]);
    off = int'(addr[3:2]);
    tg  = addr[31:7];
    hit = mv[idx] && (mt[idx] == tg);
    was_dirty = !hit && md[idx];
    rd_lat = rlat;
    wb_lat = wlat;
    if (!hit) begin
      if (md[idx]) begin
        exp_wb_addr = {mt[idx], 3'(idx)};
        exp_wb_data = mline[idx];
        model_mem[exp_wb_addr] = mline[idx];
      end
      exp_rd_addr = {tg, 3'(idx)};
      mline[idx] = model_mem.exists(exp_rd_addr) ? model_mem[exp_rd_addr] : init_block(exp_rd_addr);
      mt[idx] = tg;
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
    end
    if (wr) begin
      mline[idx][off*32 +: 32] = data;
      md[idx] = 1'b1;
    end
    exp_word  = mline[idx][off*32 +: 32];
    exp_stall = hit ? 0 : (was_dirty ? 4 + wlat + rlat : 3 + rlat);
    rd0 = rd_tx;
    wb0 = wb_tx;
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = data;
    stall = 0;
    #1;
    while (busywait && stall < 200) begin
      stall++;
      @(negedge CLK);
      #1;
    end
    checkOutput("stall", 128'(stall), 128'(exp_stall));
    if (rd) begin
      checkOutput("readdata", {96'd0, readdata}, {96'd0, exp_word});
      last_rd = exp_word;
    end
    checkOutput("rd_tx", 128'(rd_tx - rd0), hit ? 128'd0 : 128'd1);
    checkOutput("wb_tx", 128'(wb_tx - wb0), was_dirty ? 128'd1 : 128'd0);
    @(negedge CLK);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic random_phase(input int count);
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b1, 1'b0, a, 32'd0, $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        applyStimulus(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        #1;
        checkOutput("hold", {96'd0, readdata}, {96'd0, last_rd});
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          ridx;
    model_reset();
    mem_store[28'h4] = {32'd4, 32'd3, 32'd2, 32'd1};
    model_mem[28'h4] = {32'd4, 32'd3, 32'd2, 32'd1};
    repeat (2) @(negedge CLK);
    checkOutput("rst_busywait", {127'd0, busywait}, 128'd0);
    checkOutput("rst_mem_read", {127'd0, mem_read}, 128'd0);
    checkOutput("rst_mem_write", {127'd0, mem_write}, 128'd0);
    checkOutput("rst_readdata", {96'd0, readdata}, 128'd0);
    checkOutput("rst_mem_address", {100'd0, mem_address}, 128'd0);
    checkOutput("rst_mem_writedata", mem_writedata, 128'd0);
    RESET = 1'b1;
    @(negedge CLK);

    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0, 5, 0);
    #1;
    checkOutput("hold_first_miss", {96'd0, readdata}, 128'd1);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'd0, 0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'd0, 0, 0);
    #1;
    checkOutput("hold_store_hit", {96'd0, readdata}, 128'hDEAD_BEEF);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 32'h0000_00C4, 32'd0, 3, 2);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'd0, 0, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'd0, 0, 0);

    random_phase(300);

    // Abort a refill with reset while the memory is still busy.
    ra   = 32'h0800_0024;
    ridx = int'(ra[6:4]);
    rd_lat = 30;
    wb_lat = 0;
    if (md[ridx]) begin
      exp_wb_addr = {mt[ridx], 3'(ridx)};
      exp_wb_data = mline[ridx];
      model_mem[exp_wb_addr] = mline[ridx];
    end
    exp_rd_addr = {ra[31:7], ra[6:4]};
    read    = 1'b1;
    address = ra;
    repeat (md[ridx] ? 3 : 2) @(negedge CLK);
    #1;
    checkOutput("pre_rst_mem_read", {127'd0, mem_read}, 128'd1);
    checkOutput("pre_rst_busywait", {127'd0, busywait}, 128'd1);
    #1;
    RESET = 1'b0;
    #1;
    checkOutput("abort_mem_read", {127'd0, mem_read}, 128'd0);
    checkOutput("abort_busywait", {127'd0, busywait}, 128'd0);
    checkOutput("abort_mem_address", {100'd0, mem_address}, 128'd0);
    checkOutput("abort_readdata", {96'd0, readdata}, 128'd0);
    @(negedge CLK);
    read = 1'b0;
    model_reset();
    RESET = 1'b1;
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, ra, 32'd0, 1, 0);

    random_phase(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
